// File: rtl/dram_pkg.sv
// Shared types and sizes for the DRAM chunk packer.
// Build option: DRAM_CHUNK_PACKER_CHECKSUM_EN (see top module).
package dram_pkg;

    localparam int SAMPLE_WIDTH    = 16;
    localparam int CHUNK_WIDTH     = 128;
    localparam int LANES           = CHUNK_WIDTH / SAMPLE_WIDTH;
    localparam int IDX_WIDTH       = $clog2(LANES);
    localparam int DRAM_ADDR_WIDTH = 24;

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        DONE
    } packer_state_t;

    typedef logic [CHUNK_WIDTH-1:0] chunk_t;

endpackage

// File: rtl/dram_chunk_packer_if.sv
// AXI-stream style valid/ready bundle with tlast.
// Used for both the sample input and the chunk output.
interface dram_chunk_packer_if
    import dram_pkg::*;
#(
    parameter int W = SAMPLE_WIDTH
);

    logic [W-1:0] data;
    logic         valid;
    logic         tlast;
    logic         ready;

    modport master (
        output data,
        output valid,
        output tlast,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  tlast,
        output ready
    );

endinterface

// File: rtl/dram_chunk_packer_chunk_out_reg.sv
// Single-entry holding register for one chunk plus tlast.
// Holds its contents until the downstream handshake.
module chunk_out_reg
    import dram_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  chunk_t load_data,
    input  logic   load_tlast,
    input  logic   ready,
    output logic   valid,
    output chunk_t data,
    output logic   tlast
);

    // Caller only loads when the slot is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            tlast <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            tlast <= load_tlast;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_chunk_packer.sv
// Packs 16-bit samples into 128-bit chunks for the DRAM write FIFO.
// Define DRAM_CHUNK_PACKER_CHECKSUM_EN to add a running sample checksum.
module dram_chunk_packer
    import dram_pkg::*;
#(
    parameter int MAX_CHUNKS = 2 ** DRAM_ADDR_WIDTH
)
(
    input  logic                       clk,
    input  logic                       rst,
    dram_chunk_packer_if.slave         sample_axis,
    dram_chunk_packer_if.master        chunk_axis,
    output logic                       load_done,
    output logic [DRAM_ADDR_WIDTH-1:0] chunk_count,
`ifdef DRAM_CHUNK_PACKER_CHECKSUM_EN
    output logic [SAMPLE_WIDTH-1:0]    checksum,
`endif
    output logic                       overflow
);

    localparam logic [DRAM_ADDR_WIDTH:0] LAST_NUM =
        (DRAM_ADDR_WIDTH+1)'(MAX_CHUNKS - 1);

    packer_state_t          state;
    logic [IDX_WIDTH-1:0]   idx;
    chunk_t                 pack;
    chunk_t                 packed_next;
    logic                   out_valid;
    chunk_t                 out_data;
    logic                   out_tlast;
    logic                   accept;
    logic                   complete;
    logic                   handshake;
    logic                   hit_max;
    logic                   last_chunk;
    logic [DRAM_ADDR_WIDTH:0] chunk_num;

    assign sample_axis.ready = (state == FILL) &&
                               !(out_valid && !chunk_axis.ready);

    assign accept    = sample_axis.valid && sample_axis.ready;
    assign handshake = out_valid && chunk_axis.ready;
    assign complete  = accept &&
                       ((idx == IDX_WIDTH'(LANES - 1)) ||
                        sample_axis.tlast);

    // Zero-based number of the chunk being completed; a held chunk
    // that has not yet handed off still counts as already issued.
    assign chunk_num  = {1'b0, chunk_count} +
                        {{DRAM_ADDR_WIDTH{1'b0}}, out_valid};
    assign hit_max    = (chunk_num == LAST_NUM);
    assign last_chunk = sample_axis.tlast || hit_max;

    always_comb begin
        packed_next = pack;
        packed_next[idx*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
            sample_axis.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            idx         <= '0;
            pack        <= '0;
            load_done   <= 1'b0;
            overflow    <= 1'b0;
            chunk_count <= '0;
        end else begin
            if (handshake && (chunk_count != '1)) begin
                chunk_count <= chunk_count + 1'b1;
            end
            unique case (state)
                FILL: begin
                    if (complete) begin
                        pack <= '0;
                        idx  <= '0;
                        if (last_chunk) begin
                            state <= DRAIN;
                        end
                        if (hit_max && !sample_axis.tlast) begin
                            overflow <= 1'b1;
                        end
                    end else if (accept) begin
                        pack <= packed_next;
                        idx  <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        state     <= DONE;
                        load_done <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef DRAM_CHUNK_PACKER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + sample_axis.data;
        end
    end
`endif

    chunk_out_reg u_out (
        .clk        (clk),
        .rst        (rst),
        .load       (complete),
        .load_data  (packed_next),
        .load_tlast (last_chunk),
        .ready      (chunk_axis.ready),
        .valid      (out_valid),
        .data       (out_data),
        .tlast      (out_tlast)
    );

    assign chunk_axis.valid = out_valid;
    assign chunk_axis.data  = out_data;
    assign chunk_axis.tlast = out_tlast;

endmodule

// File: tb/tb_dram_chunk_packer.sv
// Bench for dram_chunk_packer with a small chunk limit.
// Checks against a list-based packing model; checksum when enabled.
module tb_dram_chunk_packer;
    import dram_pkg::*;

    localparam int MAXC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_done;
    logic [23:0] chunk_count;
    logic        overflow;
`ifdef DRAM_CHUNK_PACKER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    dram_chunk_packer_if #(.W(16))  s_if ();
    dram_chunk_packer_if #(.W(128)) c_if ();

    dram_chunk_packer #(.MAX_CHUNKS(MAXC)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_axis (s_if),
        .chunk_axis  (c_if),
        .load_done   (load_done),
        .chunk_count (chunk_count),
`ifdef DRAM_CHUNK_PACKER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0]  sq[$];
    bit           lq[$];
    logic [127:0] got_d[$];
    bit           got_l[$];
    logic [127:0] e_d[$];
    bit           e_l[$];
    bit           e_ovf;

    task automatic check(input string tag,
                         input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        s_if.valid  = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.data   = '0;
        c_if.ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Expected chunks from the sample list: lanes in order, cut at
    // eight samples, at tlast, or at the chunk limit.
    task automatic model(output int consumed);
        logic [127:0] cur;
        int lane;
        int n;
        bit last;
        e_d.delete();
        e_l.delete();
        e_ovf    = 1'b0;
        cur      = '0;
        lane     = 0;
        n        = 0;
        consumed = sq.size();
        for (int i = 0; i < sq.size(); i++) begin
            cur[lane*16 +: 16] = sq[i];
            lane++;
            if (lane == LANES || lq[i]) begin
                last = lq[i] || (n == MAXC - 1);
                e_d.push_back(cur);
                e_l.push_back(last);
                n++;
                cur  = '0;
                lane = 0;
                if (last) begin
                    e_ovf    = !lq[i];
                    consumed = i + 1;
                    break;
                end
            end
        end
    endtask

    task automatic run(input int vp, input int rp,
                       input int stall_n, output int acc);
        int si;
        int lane;
        int stall_left;
        int guard;
        bit exp_v;
        bit prev_hold;
        logic [127:0] prev_d;
        bit prev_l;
        si = 0; lane = 0; guard = 0;
        exp_v = 0; prev_hold = 0;
        prev_d = '0; prev_l = 0;
        stall_left = (stall_n > 0) ? -1 : 0;
        got_d.delete();
        got_l.delete();
        while (!load_done && guard < 3000) begin
            @(posedge clk);
            #1;
            s_if.valid = (si < sq.size()) &&
                         ($urandom_range(0, 99) < vp);
            s_if.data  = (si < sq.size()) ? sq[si] : 16'h0;
            s_if.tlast = (si < sq.size()) ? lq[si] : 1'b0;
            if (stall_left != 0) begin
                c_if.ready = 1'b0;
                if (stall_left > 0) stall_left--;
            end else begin
                c_if.ready = ($urandom_range(0, 99) < rp);
            end
            @(negedge clk);
            if (exp_v) check("latency", c_if.valid, 1);
            exp_v = 0;
            if (prev_hold) begin
                check("hold_valid", c_if.valid, 1);
                check("hold_data", c_if.data, prev_d);
                check("hold_tlast", c_if.tlast, prev_l);
            end
            if (c_if.valid && !c_if.ready)
                check("stall_sready", s_if.ready, 0);
            prev_hold = c_if.valid && !c_if.ready;
            prev_d    = c_if.data;
            prev_l    = c_if.tlast;
            if (c_if.valid && stall_left < 0)
                stall_left = stall_n;
            if (c_if.valid && c_if.ready) begin
                got_d.push_back(c_if.data);
                got_l.push_back(c_if.tlast);
            end
            if (s_if.valid && s_if.ready) begin
                lane++;
                if (lane == LANES || s_if.tlast) begin
                    exp_v = 1;
                    lane  = 0;
                end
                si++;
            end
            guard++;
        end
        check("timeout", guard < 3000, 1);
        acc = si;
        s_if.valid = 1'b0;
    endtask

    task automatic score(input string tag, input int acc);
        int consumed;
        int n;
        logic [15:0] sum;
        model(consumed);
        check({tag, "_nchunks"}, got_d.size(), e_d.size());
        n = (got_d.size() < e_d.size()) ? got_d.size() : e_d.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, got_d[i], e_d[i]);
            check({tag, "_tlast"}, got_l[i], e_l[i]);
        end
        check({tag, "_count"}, chunk_count, e_d.size());
        check({tag, "_done"}, load_done, 1);
        check({tag, "_ovf"}, overflow, e_ovf);
        check({tag, "_accepted"}, acc, consumed);
        sum = '0;
        for (int i = 0; i < consumed; i++) sum += sq[i];
`ifdef DRAM_CHUNK_PACKER_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, sum);
`endif
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            s_if.valid = 1'b1;
            s_if.data  = 16'h5a5a;
            c_if.ready = 1'b1;
            @(negedge clk);
            check({tag, "_done_sready"}, s_if.ready, 0);
            check({tag, "_done_cvalid"}, c_if.valid, 0);
        end
        s_if.valid = 1'b0;
        check({tag, "_count_hold"}, chunk_count, e_d.size());
    endtask

    initial begin
        int acc;
        int n;
        do_reset();
        @(negedge clk);
        check("rst_cvalid", c_if.valid, 0);
        check("rst_cdata", c_if.data, 0);
        check("rst_ctlast", c_if.tlast, 0);
        check("rst_sready", s_if.ready, 1);
        check("rst_done", load_done, 0);
        check("rst_count", chunk_count, 0);
        check("rst_ovf", overflow, 0);

        sq.delete(); lq.delete();
        for (int i = 1; i <= 16; i++) begin
            sq.push_back(16'(i));
            lq.push_back(i == 16);
        end
        run(100, 100, 0, acc);
        score("seq16", acc);
        check("seq16_c0",
              got_d.size() > 0 ? got_d[0] : 128'h0,
              128'h0008_0007_0006_0005_0004_0003_0002_0001);

        do_reset();
        sq = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        lq = '{0, 0, 1};
        run(100, 100, 0, acc);
        score("short3", acc);

        do_reset();
        sq.delete(); lq.delete();
        for (int i = 0; i < 24; i++) begin
            sq.push_back(16'h0100 + 16'(i));
            lq.push_back(i == 23);
        end
        run(100, 100, 20, acc);
        score("stall", acc);

        do_reset();
        sq.delete(); lq.delete();
        for (int i = 0; i < 40; i++) begin
            sq.push_back(16'h2000 + 16'(i));
            lq.push_back(0);
        end
        run(100, 100, 0, acc);
        score("ovf", acc);
        check("ovf_acc32", acc, 32);

        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            s_if.valid = 1'b1;
            s_if.data  = 16'h0700 + 16'(k);
            s_if.tlast = 1'b0;
            c_if.ready = 1'b0;
        end
        @(negedge clk);
        check("mid_held", c_if.valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        s_if.valid = 1'b0;
        @(negedge clk);
        check("mid_rst_cvalid", c_if.valid, 0);
        check("mid_rst_count", chunk_count, 0);
        for (int k = 0; k < 13; k++) begin
            @(posedge clk);
            #1;
            s_if.valid = 1'b1;
            s_if.data  = 16'h0900 + 16'(k);
            c_if.ready = 1'b1;
        end
        @(posedge clk);
        #1 s_if.valid = 1'b0;
        @(negedge clk);
        check("mid_part_count", chunk_count, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst2_count", chunk_count, 0);
        sq.delete(); lq.delete();
        for (int i = 0; i < 8; i++) begin
            sq.push_back(16'h1000 + 16'(i));
            lq.push_back(i == 7);
        end
        run(100, 100, 0, acc);
        score("clean", acc);

        for (int it = 0; it < 6; it++) begin
            do_reset();
            sq.delete(); lq.delete();
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                sq.push_back(16'($urandom));
                lq.push_back($urandom_range(0, 19) == 0);
            end
            if (n < 32) lq[n-1] = 1;
            run($urandom_range(40, 100), $urandom_range(30, 100),
                0, acc);
            score("rand", acc);
        end

`ifdef DRAM_CHUNK_PACKER_CHECKSUM_EN
        do_reset();
        sq = '{16'hFFFF, 16'h0002};
        lq = '{0, 1};
        run(100, 100, 0, acc);
        score("csum", acc);
        check("csum_val", checksum, 16'h0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
